logic_analyzer_capture_buffer: RTL and testbench
================================================

// Module: logic_analyzer_capture_buffer
// PURPOSE
// Downstream of the logic-analyzer sampler. Collects its per-sample write pulses into on-chip RAM
// (1 nibble/sample, bit n = channel n), then streams the capture to the host link as packed bytes.
// Readout uses a valid/ready byte stream (UART TX / USB FIFO). Capture is armed by the same
// control that triggers the sampler; readout starts on host request.
// PARAMETERS
// ADDR_W   12   RAM address width; capacity 2**ADDR_W samples (must hold max sample_depth)
// PORTS
// clk           in   1   system clock, all logic rising-edge
// rst_n         in   1   asynchronous active-low reset
// arm           in   1   1-cycle pulse: clear buffer, latch sample_depth, enter CAPTURE
// sample_depth  in   12  samples expected; latched on arm
// wr_pulse      in   1   sampler write strobe (1 cycle per sample)
// wr_data0..3   in   8   sampler channel bytes (all-ones = high); only bit[0] of each is used
// rd_start      in   1   1-cycle pulse: begin readout; honoured only in FULL
// out_valid     out  1   byte available on out_data
// out_data      out  8   {sample[2k+1][3:0], sample[2k][3:0]}
// out_ready     in   1   consumer accepts byte when out_valid & out_ready
// capture_done  out  1   high while in FULL
// busy          out  1   high in CAPTURE or any READ state
// overrun       out  1   sticky: wr_pulse arrived outside CAPTURE or after depth reached; cleared by arm
// sample_count  out  12  samples stored in current capture
// BEHAVIOUR
// - Reset: state IDLE; out_valid=0, out_data=0, capture_done=0, busy=0, overrun=0, sample_count=0.
// - States: IDLE, CAPTURE, FULL, RD_LO, RD_HI, PRESENT.
// - IDLE --arm--> CAPTURE (sample_count<=0, overrun<=0, depth_q<=sample_depth).
// - CAPTURE: on wr_pulse, write {d3[0],d2[0],d1[0],d0[0]} to RAM[sample_count]; count++.
//   When count reaches depth_q (same cycle as last write) -> FULL next cycle.
//   depth_q==0 -> FULL one cycle after arm, nothing written.
// - FULL --rd_start--> RD_LO with rd_ptr=0; if depth_q==0, returns straight to IDLE.
// - RD_LO: issue RAM read addr rd_ptr -> RD_HI.
// - RD_HI: latch low nibble (RAM sync read, 1-cycle latency); issue addr rd_ptr+1 -> PRESENT.
// - PRESENT: out_data={hi,lo} where hi = RAM data if rd_ptr+1<depth_q, else 4'h0 (odd-count pad).
//   out_valid=1, held stable until out_ready.
//   On accept: rd_ptr+=2; if rd_ptr+2>=depth_q -> FULL, else RD_LO. Min 3 cycles/byte.
// - Readout does not destroy data; rd_start from FULL may replay the capture any number of times.
// - Bytes per readout = ceil(depth_q/2).
// - arm in any state (incl. mid-readout): abort, drop out_valid next cycle, restart CAPTURE.
//   arm beats rd_start and wr_pulse in the same cycle (pulse ignored, not counted as overrun).
// - wr_pulse in IDLE/FULL/READ states: no write, overrun<=1.
// - sample_count never exceeds depth_q; no address wrap.
// - Async reset mid-operation returns to reset values; RAM contents undefined thereafter.
// - Widths: counters ADDR_W bits; depth compare is unsigned; rd_ptr+1/+2 computed ADDR_W+1 bits
//   so no wrap at 4095.
// STRUCTURE
// - Package la_pkg: ADDR_W default, state encoding localparams (one-hot, 6 bits), nibble pack function.
// - Sub-module la_sample_ram: simple dual-port RAM, 4-bit x 2**ADDR_W, sync write, registered read.
// - Top: FSM, write counter, read pointer, output register, overrun flag.
// TESTING
// - depth=8, 8 pulses, nibbles 1..8, rd_start, ready=1 -> 4 bytes 0x21,0x43,0x65,0x87; back to FULL.
// - depth=5, data A,B,C,D,E -> bytes 0xBA,0xDC,0x0E; capture_done held.
// - out_ready low 10 cycles in PRESENT -> out_valid/out_data stable; no byte lost or duplicated.
// - depth=0: arm -> capture_done next+1 cycle; rd_start -> no out_valid, state IDLE.
// - depth=4, 6 pulses -> count=4, overrun=1; wr_pulse in IDLE -> overrun=1; arm clears it.
// - arm during 2nd readout byte -> out_valid=0 next cycle, count=0, busy=1; rst_n low mid-CAPTURE -> all outputs reset.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types for the logic-analyzer capture buffer: address width default,
// one-hot FSM encoding and the channel-to-nibble packing helper.
package la_pkg;

  localparam int ADDR_W_DEF = 12;

  localparam logic [5:0] S_IDLE    = 6'b000001;
  localparam logic [5:0] S_CAPTURE = 6'b000010;
  localparam logic [5:0] S_FULL    = 6'b000100;
  localparam logic [5:0] S_RD_LO   = 6'b001000;
  localparam logic [5:0] S_RD_HI   = 6'b010000;
  localparam logic [5:0] S_PRESENT = 6'b100000;

  typedef enum logic [5:0] {
    ST_IDLE    = S_IDLE,
    ST_CAPTURE = S_CAPTURE,
    ST_FULL    = S_FULL,
    ST_RD_LO   = S_RD_LO,
    ST_RD_HI   = S_RD_HI,
    ST_PRESENT = S_PRESENT
  } la_state_e;

  // Bit n of the stored nibble is channel n.
  function automatic logic [3:0] pack_nibble(input logic c0, input logic c1,
                                             input logic c2, input logic c3);
    return {c3, c2, c1, c0};
  endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample store: 4-bit words, synchronous write, registered read.
// rdata holds its value while re is low, so the presented byte stays stable.
module la_sample_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [3:0]        rdata
);

  logic [3:0] mem_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/logic_analyzer_capture_buffer.sv
// Captures sampler write pulses into RAM (one nibble per sample) and replays
// the capture as packed bytes on a valid/ready stream.
module logic_analyzer_capture_buffer
  import la_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [ADDR_W-1:0] sample_depth,
  input  logic              wr_pulse,
  input  logic [7:0]        wr_data0,
  input  logic [7:0]        wr_data1,
  input  logic [7:0]        wr_data2,
  input  logic [7:0]        wr_data3,
  input  logic              rd_start,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              capture_done,
  output logic              busy,
  output logic              overrun,
  output logic [ADDR_W-1:0] sample_count
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] TWO = (ADDR_W+1)'(2);

  la_state_e         state_q;
  logic [ADDR_W-1:0] depth_q, count_q, rd_ptr_q;
  logic [3:0]        lo_q;
  logic              pad_q, out_valid_q, overrun_q;

  logic              we, re;
  logic [ADDR_W-1:0] raddr;
  logic [3:0]        rdata, wdata;
  logic [ADDR_W:0]   count_p1, rd_p1, rd_p2, depth_x;

  // Only channel bit 0 of each sampler byte carries information.
  logic unused_wr_hi;
  assign unused_wr_hi = ^{wr_data0[7:1], wr_data1[7:1], wr_data2[7:1], wr_data3[7:1]};

  assign depth_x  = {1'b0, depth_q};
  assign count_p1 = {1'b0, count_q} + ONE;
  assign rd_p1    = {1'b0, rd_ptr_q} + ONE;
  assign rd_p2    = {1'b0, rd_ptr_q} + TWO;

  assign wdata = pack_nibble(wr_data0[0], wr_data1[0], wr_data2[0], wr_data3[0]);
  assign we    = (state_q == ST_CAPTURE) && wr_pulse && !arm && (count_q < depth_q);
  assign re    = (state_q == ST_RD_LO) || (state_q == ST_RD_HI);
  assign raddr = (state_q == ST_RD_HI) ? rd_p1[ADDR_W-1:0] : rd_ptr_q;

  la_sample_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (count_q),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      depth_q     <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      lo_q        <= '0;
      pad_q       <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (arm) begin
      // arm wins over everything, including a same-cycle wr_pulse/rd_start
      state_q     <= ST_CAPTURE;
      depth_q     <= sample_depth;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (wr_pulse && !we) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: ;
        ST_CAPTURE: begin
          if (we) begin
            count_q <= count_p1[ADDR_W-1:0];
            if (count_p1 == depth_x) state_q <= ST_FULL;
          end else if (count_q == depth_q) begin
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (rd_start) begin
            rd_ptr_q <= '0;
            state_q  <= (depth_q == '0) ? ST_IDLE : ST_RD_LO;
          end
        end
        ST_RD_LO: state_q <= ST_RD_HI;
        ST_RD_HI: begin
          lo_q        <= rdata;
          pad_q       <= !(rd_p1 < depth_x);
          out_valid_q <= 1'b1;
          state_q     <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            rd_ptr_q    <= rd_p2[ADDR_W-1:0];
            state_q     <= (rd_p2 >= depth_x) ? ST_FULL : ST_RD_LO;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // High nibble comes straight from the RAM read register, frozen during PRESENT.
  assign out_valid    = out_valid_q;
  assign out_data     = out_valid_q ? {(pad_q ? 4'h0 : rdata), lo_q} : 8'h00;
  assign capture_done = (state_q == ST_FULL);
  assign busy         = (state_q == ST_CAPTURE) || (state_q == ST_RD_LO) ||
                        (state_q == ST_RD_HI)   || (state_q == ST_PRESENT);
  assign overrun      = overrun_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_logic_analyzer_capture_buffer.sv
// Directed bench for the capture buffer: capture, packed readout, stalls,
// odd depth padding, zero depth, overrun, abort by arm and async reset.
module tb_logic_analyzer_capture_buffer;

  logic        clk, rst_n, arm, wr_pulse, rd_start, out_ready;
  logic [11:0] sample_depth;
  logic [7:0]  wr_data0, wr_data1, wr_data2, wr_data3;
  logic        out_valid, capture_done, busy, overrun;
  logic [7:0]  out_data;
  logic [11:0] sample_count;

  int total = 0;
  int bad   = 0;

  logic_analyzer_capture_buffer #(.ADDR_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .sample_depth (sample_depth),
    .wr_pulse     (wr_pulse),
    .wr_data0     (wr_data0),
    .wr_data1     (wr_data1),
    .wr_data2     (wr_data2),
    .wr_data3     (wr_data3),
    .rd_start     (rd_start),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .capture_done (capture_done),
    .busy         (busy),
    .overrun      (overrun),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm(input logic [11:0] depth);
    arm = 1'b1;
    sample_depth = depth;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] nib);
    wr_data0 = nib[0] ? 8'hFF : 8'h00;
    wr_data1 = nib[1] ? 8'hFF : 8'h00;
    wr_data2 = nib[2] ? 8'hFF : 8'h00;
    wr_data3 = nib[3] ? 8'hFF : 8'h00;
    wr_pulse = 1'b1;
    tick();
    wr_pulse = 1'b0;
  endtask

  task automatic start_read();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
  endtask

  task automatic read_byte(input logic [7:0] exp, input string tag);
    wait_valid(tag);
    chk(tag, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"},  32'(out_data), 0);
    chk({tag, "_done"},  32'(capture_done), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_ovr"},   32'(overrun), 0);
    chk({tag, "_cnt"},   32'(sample_count), 0);
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; wr_pulse = 1'b0; rd_start = 1'b0; out_ready = 1'b0;
    sample_depth = '0;
    wr_data0 = '0; wr_data1 = '0; wr_data2 = '0; wr_data3 = '0;
    tick(); tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // depth 8, nibbles 1..8
    do_arm(12'd8);
    chk("arm8_busy", 32'(busy), 1);
    chk("arm8_cnt", 32'(sample_count), 0);
    for (int i = 1; i <= 8; i++) pulse(4'(i));
    chk("cap8_cnt", 32'(sample_count), 8);
    chk("cap8_done", 32'(capture_done), 1);
    chk("cap8_busy", 32'(busy), 0);
    chk("cap8_ovr", 32'(overrun), 0);
    start_read();
    chk("rd8_busy", 32'(busy), 1);
    chk("rd8_done", 32'(capture_done), 0);
    read_byte(8'h21, "rd8_b0");
    read_byte(8'h43, "rd8_b1");
    read_byte(8'h65, "rd8_b2");
    read_byte(8'h87, "rd8_b3");
    chk("rd8_end_done", 32'(capture_done), 1);
    chk("rd8_end_valid", 32'(out_valid), 0);

    // replay of the same capture
    start_read();
    read_byte(8'h21, "rep_b0");
    read_byte(8'h43, "rep_b1");
    read_byte(8'h65, "rep_b2");
    read_byte(8'h87, "rep_b3");
    chk("rep_done", 32'(capture_done), 1);

    // depth 5, odd pad, with a 10-cycle stall on the first byte
    do_arm(12'd5);
    pulse(4'hA); pulse(4'hB); pulse(4'hC); pulse(4'hD); pulse(4'hE);
    chk("cap5_cnt", 32'(sample_count), 5);
    chk("cap5_done", 32'(capture_done), 1);
    start_read();
    wait_valid("stall_first");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'hBA);
    end
    read_byte(8'hBA, "rd5_b0");
    read_byte(8'hDC, "rd5_b1");
    read_byte(8'h0E, "rd5_b2");
    chk("rd5_done", 32'(capture_done), 1);
    chk("rd5_valid", 32'(out_valid), 0);
    tick();
    chk("rd5_no_extra", 32'(out_valid), 0);

    // depth 0
    do_arm(12'd0);
    chk("d0_done_early", 32'(capture_done), 0);
    chk("d0_busy", 32'(busy), 1);
    tick();
    chk("d0_done", 32'(capture_done), 1);
    start_read();
    chk("d0_idle_done", 32'(capture_done), 0);
    chk("d0_idle_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("d0_no_valid", 32'(out_valid), 0);
    end

    // overrun: wr_pulse in IDLE, then too many pulses
    pulse(4'h5);
    chk("idle_ovr", 32'(overrun), 1);
    chk("idle_cnt", 32'(sample_count), 0);
    do_arm(12'd4);
    chk("arm4_ovr_clr", 32'(overrun), 0);
    pulse(4'h1); pulse(4'h2); pulse(4'h3); pulse(4'h4);
    chk("cap4_ovr_pre", 32'(overrun), 0);
    pulse(4'hF); pulse(4'hF);
    chk("cap4_cnt", 32'(sample_count), 4);
    chk("cap4_ovr", 32'(overrun), 1);

    // arm aborts during the second readout byte
    start_read();
    read_byte(8'h21, "ab_b0");
    wait_valid("ab_b1");
    chk("ab_b1_data", 32'(out_data), 32'h43);
    do_arm(12'd4);
    chk("ab_valid", 32'(out_valid), 0);
    chk("ab_cnt", 32'(sample_count), 0);
    chk("ab_busy", 32'(busy), 1);
    chk("ab_ovr", 32'(overrun), 0);
    chk("ab_done", 32'(capture_done), 0);

    // arm beats a same-cycle wr_pulse
    arm = 1'b1; wr_pulse = 1'b1; sample_depth = 12'd4;
    tick();
    arm = 1'b0; wr_pulse = 1'b0;
    chk("armwr_cnt", 32'(sample_count), 0);
    chk("armwr_ovr", 32'(overrun), 0);
    pulse(4'h9); pulse(4'h6);
    chk("mid_cnt", 32'(sample_count), 2);
    chk("mid_busy", 32'(busy), 1);

    // asynchronous reset mid-capture
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
